ctrl_config_fecha: RTL and testbench

Keyboard-driven edit controller for the date fields (day, month, year).
- Decodes PS/2 scan codes into the edit-mode flag f2 and the field selector posicion that drive the per-field BCD counters.
- On commit, snapshots the three BCD values and writes them to the RTC register interface with a req/ack handshake.
- Sits between the PS/2 receiver, the field counters and the RTC bus master.

---
 rtl/ctrl_config_fecha.sv | 205 ++++++++++++++++++++
 tb/tb_ctrl_config_fecha.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_config_fecha.sv
// Purpose : keyboard-driven date edit controller; decodes PS/2 keys into f2/posicion
//           and writes the committed day/month/year snapshot to the RTC over req/ack.
// Latency : key events act on the edge they are sampled; first wr_req rises on the
//           commit edge, one idle wr_req cycle separates consecutive writes.
// Backpressure: each write holds wr_req with stable addr/data until wr_ack; a write
//           left unacknowledged for TIMEOUT cycles aborts the sequence with err.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   en_codigo, key_code      scan-code strobe and code from the PS/2 receiver
//   dato_dia/mes/year        BCD values from the field counters
//   wr_ack                   RTC bus master accepted the current write
//   posicion, f2             field selector and edit-mode flag to the counters
//   wr_req/addr/data         write request to the RTC bus
//   busy, done, err          sequence status; done/err are one-cycle pulses
module ctrl_config_fecha #(
   parameter int          N         = 8,
   parameter int          P         = 2,
   parameter logic [7:0]  ADDR_DIA  = 8'h24,
   parameter logic [7:0]  ADDR_MES  = 8'h25,
   parameter logic [7:0]  ADDR_YEAR = 8'h26,
   parameter logic [15:0] TIMEOUT   = 16'd1000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_codigo,
   input  logic [N-1:0] key_code,
   input  logic [N-1:0] dato_dia,
   input  logic [N-1:0] dato_mes,
   input  logic [N-1:0] dato_year,
   input  logic         wr_ack,
   output logic [P-1:0] posicion,
   output logic         f2,
   output logic         wr_req,
   output logic [N-1:0] wr_addr,
   output logic [N-1:0] wr_data,
   output logic         busy,
   output logic         done,
   output logic         err
);

   // Scan codes of interest
   localparam logic [N-1:0] KEY_F2    = N'(8'h06);
   localparam logic [N-1:0] KEY_RIGHT = N'(8'h74);
   localparam logic [N-1:0] KEY_LEFT  = N'(8'h6B);
   localparam logic [N-1:0] KEY_ENTER = N'(8'h5A);
   localparam logic [N-1:0] KEY_ESC   = N'(8'h76);

   // Highest legal field index / posicion value (year)
   localparam logic [P-1:0] POS_MAX = P'(2);
   localparam logic [1:0]   IDX_MAX = 2'd2;

   localparam logic [15:0]  TMO_LAST = TIMEOUT - 16'd1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EDIT,
      S_WR_REQ,
      S_GAP,
      S_DONE
   } state_t;

   state_t         state, state_nxt;
   logic [P-1:0]   pos_q, pos_nxt;
   logic [1:0]     idx_q, idx_nxt;
   logic [N-1:0]   snap_dia_q, snap_dia_nxt;
   logic [N-1:0]   snap_mes_q, snap_mes_nxt;
   logic [N-1:0]   snap_year_q, snap_year_nxt;
   logic [15:0]    tmo_q, tmo_nxt;
   logic           err_q, err_nxt;

   // Key decode: every key qualifier already includes the strobe
   logic k_f2, k_right, k_left, k_enter, k_esc;

   always_comb begin
      k_f2    = en_codigo && (key_code == KEY_F2);
      k_right = en_codigo && (key_code == KEY_RIGHT);
      k_left  = en_codigo && (key_code == KEY_LEFT);
      k_enter = en_codigo && (key_code == KEY_ENTER);
      k_esc   = en_codigo && (key_code == KEY_ESC);
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         pos_q       <= '0;
         idx_q       <= '0;
         snap_dia_q  <= '0;
         snap_mes_q  <= '0;
         snap_year_q <= '0;
         tmo_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         state       <= state_nxt;
         pos_q       <= pos_nxt;
         idx_q       <= idx_nxt;
         snap_dia_q  <= snap_dia_nxt;
         snap_mes_q  <= snap_mes_nxt;
         snap_year_q <= snap_year_nxt;
         tmo_q       <= tmo_nxt;
         err_q       <= err_nxt;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_nxt     = state;
      pos_nxt       = pos_q;
      idx_nxt       = idx_q;
      snap_dia_nxt  = snap_dia_q;
      snap_mes_nxt  = snap_mes_q;
      snap_year_nxt = snap_year_q;
      tmo_nxt       = tmo_q;
      err_nxt       = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (k_f2) begin
               state_nxt = S_EDIT;
               pos_nxt   = '0;
            end
         end

         S_EDIT: begin
            if (k_enter) begin
               // Freeze the counters' values; later input changes are not written
               state_nxt     = S_WR_REQ;
               snap_dia_nxt  = dato_dia;
               snap_mes_nxt  = dato_mes;
               snap_year_nxt = dato_year;
               idx_nxt       = '0;
               tmo_nxt       = '0;
            end else if (k_esc) begin
               // posicion deliberately retained on cancel
               state_nxt = S_IDLE;
            end else if (k_right) begin
               pos_nxt = (pos_q >= POS_MAX) ? '0 : pos_q + P'(1);
            end else if (k_left) begin
               pos_nxt = (pos_q == '0) ? POS_MAX : pos_q - P'(1);
            end
         end

         S_WR_REQ: begin
            // An ack on the last allowed cycle still counts as success
            if (wr_ack) begin
               state_nxt = S_GAP;
            end else if (tmo_q == TMO_LAST) begin
               state_nxt = S_IDLE;
               err_nxt   = 1'b1;
               tmo_nxt   = '0;
            end else begin
               tmo_nxt = tmo_q + 16'd1;
            end
         end

         S_GAP: begin
            if (idx_q == IDX_MAX) begin
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_WR_REQ;
               idx_nxt   = idx_q + 2'd1;
               tmo_nxt   = '0;
            end
         end

         S_DONE: begin
            state_nxt = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from registered state, so they change only on clk edges
   always_comb begin
      f2       = (state == S_EDIT);
      wr_req   = (state == S_WR_REQ);
      busy     = (state == S_WR_REQ) || (state == S_GAP) || (state == S_DONE);
      done     = (state == S_DONE);
      err      = err_q;
      posicion = pos_q;
      wr_addr  = '0;
      wr_data  = '0;
      if (state == S_WR_REQ) begin
         unique case (idx_q)
            2'd0: begin
               wr_addr = N'(ADDR_DIA);
               wr_data = snap_dia_q;
            end
            2'd1: begin
               wr_addr = N'(ADDR_MES);
               wr_data = snap_mes_q;
            end
            default: begin
               wr_addr = N'(ADDR_YEAR);
               wr_data = snap_year_q;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ctrl_config_fecha.sv
module tb_ctrl_config_fecha;

   logic       clk = 1'b0;
   logic       rst;
   logic       en_codigo;
   logic [7:0] key_code;
   logic [7:0] dato_dia, dato_mes, dato_year;
   logic       wr_ack;
   logic [1:0] posicion;
   logic       f2, wr_req, busy, done, err;
   logic [7:0] wr_addr, wr_data;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   int req_cnt  = 0;

   localparam logic [7:0] K_F2 = 8'h06, K_RIGHT = 8'h74, K_LEFT = 8'h6B,
                          K_ENTER = 8'h5A, K_ESC = 8'h76;

   ctrl_config_fecha dut (
      .clk       (clk),
      .rst       (rst),
      .en_codigo (en_codigo),
      .key_code  (key_code),
      .dato_dia  (dato_dia),
      .dato_mes  (dato_mes),
      .dato_year (dato_year),
      .wr_ack    (wr_ack),
      .posicion  (posicion),
      .f2        (f2),
      .wr_req    (wr_req),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Pulse counters and wr_req rising-edge counter, sampled mid-cycle
   logic wr_req_d = 1'b0;
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (wr_req && !wr_req_d) req_cnt++;
      wr_req_d <= wr_req;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs set afterwards apply at the next edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [7:0] code);
      en_codigo = 1'b1;
      key_code  = code;
      step();
      en_codigo = 1'b0;
   endtask

   logic [7:0] exp_addr [3] = '{8'h24, 8'h25, 8'h26};
   logic [7:0] exp_data [3] = '{8'h31, 8'h12, 8'h99};

   initial begin
      int n;
      int d0, e0, r0;
      rst = 1'b1; en_codigo = 1'b0; key_code = 8'h00; wr_ack = 1'b0;
      dato_dia = 8'h00; dato_mes = 8'h00; dato_year = 8'h00;
      step();
      check("rst_f2", f2, 0);
      check("rst_pos", posicion, 0);
      check("rst_wr_req", wr_req, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_addr", wr_addr, 0);
      step();
      rst = 1'b0;
      step();

      // Enter edit and navigate
      press(K_F2);
      check("f2_enter", f2, 1);
      check("f2_pos0", posicion, 0);
      press(K_RIGHT); check("right1", posicion, 1);
      press(K_RIGHT); check("right2", posicion, 2);
      press(K_RIGHT); check("right_wrap", posicion, 0);
      press(K_LEFT);  check("left_wrap", posicion, 2);
      press(8'h75);   check("unknown_key", posicion, 2);
      press(K_F2);    check("f2_in_edit_pos", posicion, 2);
      check("f2_in_edit_f2", f2, 1);
      key_code = K_LEFT; step(); // no strobe
      check("no_strobe", posicion, 2);

      // Reset mid-edit
      rst = 1'b1; step(); rst = 1'b0;
      check("rst_edit_f2", f2, 0);
      check("rst_edit_pos", posicion, 0);

      // Esc cancels, posicion retained, no writes
      r0 = req_cnt;
      press(K_F2);
      press(K_RIGHT);
      press(K_ESC);
      check("esc_f2", f2, 0);
      check("esc_pos", posicion, 1);
      repeat (5) step();
      check("esc_no_req", req_cnt - r0, 0);
      check("esc_busy", busy, 0);

      // Full commit with ack two cycles after each request
      d0 = done_cnt; e0 = err_cnt; r0 = req_cnt;
      press(K_F2);
      dato_dia = 8'h31; dato_mes = 8'h12; dato_year = 8'h99;
      press(K_ENTER);
      check("commit_f2", f2, 0);
      check("commit_busy", busy, 1);
      dato_dia = 8'h01; dato_mes = 8'h05; dato_year = 8'h20;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("w%0d_req", k), wr_req, 1);
         check($sformatf("w%0d_addr", k), wr_addr, exp_addr[k]);
         check($sformatf("w%0d_data", k), wr_data, exp_data[k]);
         step();
         check($sformatf("w%0d_hold_addr", k), wr_addr, exp_addr[k]);
         check($sformatf("w%0d_hold_data", k), wr_data, exp_data[k]);
         wr_ack = 1'b1;
         step();
         wr_ack = 1'b0;
         check($sformatf("w%0d_gap_req", k), wr_req, 0);
         check($sformatf("w%0d_gap_busy", k), busy, 1);
         step();
      end
      check("done_pulse", done, 1);
      check("done_busy", busy, 1);
      step();
      check("done_clear", done, 0);
      check("post_busy", busy, 0);
      check("done_count", done_cnt - d0, 1);
      check("req_count", req_cnt - r0, 3);
      check("no_err", err_cnt - e0, 0);

      // Timeout on the first write
      d0 = done_cnt; e0 = err_cnt;
      press(K_F2);
      press(K_ENTER);
      n = 0;
      while (wr_req && n < 2000) begin
         n++;
         step();
      end
      check("tmo_cycles", n, 1000);
      check("tmo_req", wr_req, 0);
      check("tmo_err", err, 1);
      step();
      check("tmo_err_clear", err, 0);
      check("tmo_busy", busy, 0);
      check("tmo_err_count", err_cnt - e0, 1);
      check("tmo_no_done", done_cnt - d0, 0);
      press(K_F2);
      check("tmo_reenter_f2", f2, 1);
      check("tmo_reenter_pos", posicion, 0);

      // Reset during the month write
      d0 = done_cnt; e0 = err_cnt;
      press(K_ENTER);
      step();
      wr_ack = 1'b1; step(); wr_ack = 1'b0;
      step();
      check("mid_addr", wr_addr, 8'h25);
      check("mid_req", wr_req, 1);
      rst = 1'b1; step(); rst = 1'b0;
      check("mid_rst_req", wr_req, 0);
      check("mid_rst_busy", busy, 0);
      repeat (3) step();
      check("mid_no_done", done_cnt - d0, 0);
      check("mid_no_err", err_cnt - e0, 0);
      press(K_F2);
      check("mid_restart_f2", f2, 1);
      dato_dia = 8'h07;
      press(K_ENTER);
      check("mid_restart_addr", wr_addr, 8'h24);
      check("mid_restart_data", wr_data, 8'h07);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
